// File: rtl/map_store_pkg.sv
// Shared tile codes, hit-result codes and map geometry for map_store and the renderer.
package map_store_pkg;
    localparam int MAP_W_DEF = 25;
    localparam int MAP_H_DEF = 18;
    localparam int TILE_PX   = 8;
    localparam int ADDR_W    = 9;

    typedef enum logic [1:0] {
        TILE_EMPTY = 2'd0,
        TILE_BRICK = 2'd1,
        TILE_STEEL = 2'd2,
        TILE_RSVD  = 2'd3
    } tile_t;

    typedef enum logic [1:0] {
        HIT_NONE      = 2'd0,
        HIT_DAMAGED   = 2'd1,
        HIT_DESTROYED = 2'd2,
        HIT_SOLID     = 2'd3
    } hit_t;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } map_state_t;

    // Linear storage address of tile (x, y) in a map that is w tiles wide.
    function automatic logic [ADDR_W-1:0] tile_addr(input logic [4:0] x, input logic [4:0] y,
                                                     input logic [ADDR_W-1:0] w);
        return (ADDR_W'(y) * w) + ADDR_W'(x);
    endfunction
endpackage

// File: rtl/map_layout_rom.sv
// Built-in map layouts: i_layout=0 is the arena, i_layout=1 is an all-empty map.
module map_layout_rom
    import map_store_pkg::*;
(
    input  logic       i_layout,
    input  logic [4:0] i_x,
    input  logic [4:0] i_y,
    output logic [1:0] o_tile
);
    // Arena: steel core, two brick columns, two brick rows with a gap at the centre column.
    always_comb begin
        o_tile = TILE_EMPTY;
        if (i_layout) begin
            o_tile = TILE_EMPTY;
        end else if (i_x == 5'd12 && i_y >= 5'd7 && i_y <= 5'd10) begin
            o_tile = TILE_STEEL;
        end else if ((i_x == 5'd4 || i_x == 5'd20) && i_y >= 5'd3 && i_y <= 5'd14) begin
            o_tile = TILE_BRICK;
        end else if ((i_y == 5'd3 || i_y == 5'd14) && i_x >= 5'd8 && i_x <= 5'd16 && i_x != 5'd12) begin
            o_tile = TILE_BRICK;
        end else begin
            o_tile = TILE_EMPTY;
        end
    end
endmodule

// File: rtl/map_store.sv
// Tile-map owner: layout load, two combinational read ports, bullet-hit processing.
// Optional macro MAP_BRICK_HP_EN gives bricks a damage bit so they take two hits.
module map_store
    import map_store_pkg::*;
#(
    parameter int MAP_W  = MAP_W_DEF,
    parameter int MAP_H  = MAP_H_DEF,
    parameter int LAYOUT = 0
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       load,
    output logic       ready,
    input  logic [4:0] map_rd_x,
    input  logic [4:0] map_rd_y,
    output logic [1:0] map_tile,
    input  logic [4:0] q_x,
    input  logic [4:0] q_y,
    output logic [1:0] q_tile,
    input  logic       hit_req,
    input  logic [4:0] hit_x,
    input  logic [4:0] hit_y,
    output logic       hit_ack,
    output logic [1:0] hit_result,
    output logic [8:0] bricks_left
);
    localparam int                N       = MAP_W * MAP_H;
    localparam logic [4:0]        W5      = 5'(MAP_W);
    localparam logic [4:0]        H5      = 5'(MAP_H);
    localparam logic [ADDR_W-1:0] WA      = ADDR_W'(MAP_W);
    localparam logic              L_EMPTY = (LAYOUT == 1);

    map_state_t        r_state;
    map_state_t        w_state_nxt;
    logic [1:0]        r_map [0:N-1];
    logic [4:0]        r_scan_x;
    logic [4:0]        r_scan_y;
    logic              r_ready;
    logic              r_hit_ack;
    logic [1:0]        r_hit_result;
    logic [8:0]        r_bricks;
`ifdef MAP_BRICK_HP_EN
    logic [N-1:0]      r_dmg;
    logic              w_dmg_set;
    logic              w_dmg_clr;
`endif

    logic [ADDR_W-1:0] w_scan_addr;
    logic [ADDR_W-1:0] w_hit_addr;
    logic [ADDR_W-1:0] w_rd_addr;
    logic [ADDR_W-1:0] w_q_addr;
    logic              w_scan_last;
    logic              w_hit_in;
    logic              w_rd_in;
    logic              w_q_in;
    logic [1:0]        w_rom_tile;
    logic [1:0]        w_hit_tile;
    logic              w_accept;
    hit_t              w_result;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [1:0]        w_wr_data;
    logic              w_brick_inc;
    logic              w_brick_dec;

    assign w_scan_addr = tile_addr(r_scan_x, r_scan_y, WA);
    assign w_hit_addr  = tile_addr(hit_x, hit_y, WA);
    assign w_rd_addr   = tile_addr(map_rd_x, map_rd_y, WA);
    assign w_q_addr    = tile_addr(q_x, q_y, WA);
    assign w_scan_last = (r_scan_x == W5 - 5'd1) && (r_scan_y == H5 - 5'd1);
    assign w_hit_in    = (hit_x < W5) && (hit_y < H5);
    assign w_rd_in     = (map_rd_x < W5) && (map_rd_y < H5);
    assign w_q_in      = (q_x < W5) && (q_y < H5);
    assign w_hit_tile  = r_map[w_hit_addr];

    map_layout_rom u_rom (
        .i_layout (L_EMPTY),
        .i_x      (r_scan_x),
        .i_y      (r_scan_y),
        .o_tile   (w_rom_tile)
    );

    // Next state, layout write during INIT and hit evaluation during READY.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_result    = HIT_NONE;
        w_wr_en     = 1'b0;
        w_wr_addr   = w_scan_addr;
        w_wr_data   = TILE_EMPTY;
        w_brick_inc = 1'b0;
        w_brick_dec = 1'b0;
`ifdef MAP_BRICK_HP_EN
        w_dmg_set   = 1'b0;
        w_dmg_clr   = 1'b0;
`endif
        if (load) begin
            w_state_nxt = ST_INIT;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_wr_en     = 1'b1;
                    w_wr_data   = w_rom_tile;
                    w_brick_inc = (w_rom_tile == TILE_BRICK);
`ifdef MAP_BRICK_HP_EN
                    w_dmg_clr   = 1'b1;
`endif
                    if (w_scan_last) begin
                        w_state_nxt = ST_READY;
                    end else begin
                        w_state_nxt = ST_INIT;
                    end
                end
                ST_READY: begin
                    w_state_nxt = ST_READY;
                    if (hit_req) begin
                        w_accept  = 1'b1;
                        w_wr_addr = w_hit_addr;
                        if (!w_hit_in) begin
                            w_result = HIT_SOLID;
                        end else if (w_hit_tile == TILE_BRICK) begin
`ifdef MAP_BRICK_HP_EN
                            if (r_dmg[w_hit_addr]) begin
                                w_result    = HIT_DESTROYED;
                                w_wr_en     = 1'b1;
                                w_brick_dec = 1'b1;
                                w_dmg_clr   = 1'b1;
                            end else begin
                                w_result    = HIT_DAMAGED;
                                w_dmg_set   = 1'b1;
                            end
`else
                            w_result    = HIT_DESTROYED;
                            w_wr_en     = 1'b1;
                            w_brick_dec = 1'b1;
`endif
                        end else if (w_hit_tile == TILE_STEEL) begin
                            w_result = HIT_SOLID;
                        end else begin
                            w_result = HIT_NONE;
                        end
                    end else begin
                        w_accept = 1'b0;
                    end
                end
                default: w_state_nxt = ST_INIT;
            endcase
        end
    end

    // Control registers: state, scan counter, brick count and hit response.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_state      <= ST_INIT;
            r_ready      <= 1'b0;
            r_scan_x     <= 5'd0;
            r_scan_y     <= 5'd0;
            r_bricks     <= 9'd0;
            r_hit_ack    <= 1'b0;
            r_hit_result <= 2'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_ready      <= (w_state_nxt == ST_READY);
            r_hit_ack    <= w_accept;
            r_hit_result <= w_accept ? w_result : HIT_NONE;
            if (load) begin
                r_scan_x <= 5'd0;
                r_scan_y <= 5'd0;
            end else if (r_state == ST_INIT) begin
                if (r_scan_x == W5 - 5'd1) begin
                    r_scan_x <= 5'd0;
                    r_scan_y <= w_scan_last ? 5'd0 : r_scan_y + 5'd1;
                end else begin
                    r_scan_x <= r_scan_x + 5'd1;
                end
            end
            if (load) begin
                r_bricks <= 9'd0;
            end else if (w_brick_inc) begin
                r_bricks <= r_bricks + 9'd1;
            end else if (w_brick_dec) begin
                r_bricks <= r_bricks - 9'd1;
            end
        end
    end

    // Tile storage; rewritten in full by every INIT so it needs no reset.
    always_ff @(posedge pclk) begin
        if (!rst && w_wr_en) begin
            r_map[w_wr_addr] <= w_wr_data;
        end
    end

`ifdef MAP_BRICK_HP_EN
    // Per-tile damage bits, cleared during INIT and when a brick is destroyed.
    always_ff @(posedge pclk) begin
        if (rst) begin
            r_dmg <= '0;
        end else if (w_dmg_set) begin
            r_dmg[w_wr_addr] <= 1'b1;
        end else if (w_dmg_clr) begin
            r_dmg[w_wr_addr] <= 1'b0;
        end
    end
`endif

    // Read ports: empty while loading, steel outside the map.
    always_comb begin
        map_tile = TILE_EMPTY;
        q_tile   = TILE_EMPTY;
        if (r_state == ST_INIT) begin
            map_tile = TILE_EMPTY;
            q_tile   = TILE_EMPTY;
        end else begin
            map_tile = w_rd_in ? r_map[w_rd_addr] : TILE_STEEL;
            q_tile   = w_q_in  ? r_map[w_q_addr]  : TILE_STEEL;
        end
    end

    assign ready       = r_ready;
    assign hit_ack     = r_hit_ack;
    assign hit_result  = r_hit_result;
    assign bricks_left = r_bricks;
endmodule

// File: tb/tb_map_store.sv
// Self-checking bench for map_store: directed vectors plus randomized hits against a tile-grid model.
module tb_map_store;
    logic       pclk;
    logic       rst;
    logic       load;
    logic       ready;
    logic [4:0] map_rd_x;
    logic [4:0] map_rd_y;
    logic [1:0] map_tile;
    logic [4:0] q_x;
    logic [4:0] q_y;
    logic [1:0] q_tile;
    logic       hit_req;
    logic [4:0] hit_x;
    logic [4:0] hit_y;
    logic       hit_ack;
    logic [1:0] hit_result;
    logic [8:0] bricks_left;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: tile grid, damage flags, brick count.
    int mdl [18][25];
    bit dmg [18][25];
    int m_bricks;

    typedef struct {
        int x;
        int y;
        int res;
        int bricks;
    } vec_t;
    vec_t tbl [7];

    map_store dut (
        .pclk(pclk), .rst(rst), .load(load), .ready(ready),
        .map_rd_x(map_rd_x), .map_rd_y(map_rd_y), .map_tile(map_tile),
        .q_x(q_x), .q_y(q_y), .q_tile(q_tile),
        .hit_req(hit_req), .hit_x(hit_x), .hit_y(hit_y),
        .hit_ack(hit_ack), .hit_result(hit_result), .bricks_left(bricks_left)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int y = 0; y < 18; y++)
            for (int x = 0; x < 25; x++) begin
                mdl[y][x] = 0;
                dmg[y][x] = 1'b0;
            end
        for (int y = 3; y <= 14; y++) begin
            mdl[y][4]  = 1;
            mdl[y][20] = 1;
        end
        for (int x = 8; x <= 16; x++)
            if (x != 12) begin
                mdl[3][x]  = 1;
                mdl[14][x] = 1;
            end
        for (int y = 7; y <= 10; y++) mdl[y][12] = 2;
        m_bricks = 0;
        for (int y = 0; y < 18; y++)
            for (int x = 0; x < 25; x++)
                if (mdl[y][x] == 1) m_bricks++;
    endtask

    function automatic int model_rd(input int x, input int y);
        if (x >= 25 || y >= 18) return 2;
        return mdl[y][x];
    endfunction

    task automatic model_hit(input int x, input int y, output int res);
        if (x >= 25 || y >= 18) res = 3;
        else if (mdl[y][x] == 2) res = 3;
        else if (mdl[y][x] == 0) res = 0;
        else begin
`ifdef MAP_BRICK_HP_EN
            if (dmg[y][x]) begin
                mdl[y][x] = 0; dmg[y][x] = 1'b0; m_bricks--; res = 2;
            end else begin
                dmg[y][x] = 1'b1; res = 1;
            end
`else
            mdl[y][x] = 0; m_bricks--; res = 2;
`endif
        end
    endtask

    task automatic full_map_check();
        for (int y = 0; y < 20; y++)
            for (int x = 0; x < 27; x++) begin
                map_rd_x = 5'(x); map_rd_y = 5'(y);
                q_x = 5'(26 - x); q_y = 5'(19 - y);
                #1;
                check("map_tile_scan", {30'd0, map_tile}, model_rd(x, y));
                check("q_tile_scan", {30'd0, q_tile}, model_rd(26 - x, 19 - y));
            end
        @(negedge pclk);
    endtask

    task automatic wait_ready(output int cyc, output int acks);
        cyc = 0;
        acks = 0;
        while (ready !== 1'b1 && cyc < 1000) begin
            @(posedge pclk);
            cyc++;
            @(negedge pclk);
            if (hit_ack === 1'b1) acks++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {31'd0, ready}, 0);
        check({tag, "_hit_ack"}, {31'd0, hit_ack}, 0);
        check({tag, "_hit_result"}, {30'd0, hit_result}, 0);
        check({tag, "_bricks_left"}, {23'd0, bricks_left}, 0);
    endtask

    initial begin
        int cyc, acks, res, exp_res, req, hx, hy, rx, ry;
        rst = 1'b1; load = 1'b0; hit_req = 1'b0; hit_x = 5'd0; hit_y = 5'd0;
        map_rd_x = 5'd0; map_rd_y = 5'd0; q_x = 5'd0; q_y = 5'd0;

        // Power-on reset and first layout load.
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("por");
        rst = 1'b0;
        wait_ready(cyc, acks);
        check("por_ready_latency", cyc, 450);
        check("por_bricks", {23'd0, bricks_left}, 40);
        map_rd_x = 5'd12; map_rd_y = 5'd8; #1 check("tile_12_8", {30'd0, map_tile}, 2);
        map_rd_x = 5'd4;  map_rd_y = 5'd3; #1 check("tile_4_3", {30'd0, map_tile}, 1);
        map_rd_x = 5'd0;  map_rd_y = 5'd0; #1 check("tile_0_0", {30'd0, map_tile}, 0);
        model_reset();
        full_map_check();

        // Directed hit vectors: coordinates, expected result and brick count.
        tbl[0] = '{12, 7, 3, 40};
        tbl[1] = '{0, 0, 0, 40};
        tbl[2] = '{30, 2, 3, 40};
        tbl[4] = '{25, 0, 3, 39};
        tbl[5] = '{0, 18, 3, 39};
        tbl[6] = '{24, 17, 0, 39};
`ifdef MAP_BRICK_HP_EN
        tbl[3] = '{4, 5, 1, 40};
        tbl[4].bricks = 40; tbl[5].bricks = 40; tbl[6].bricks = 40;
`else
        tbl[3] = '{4, 5, 2, 39};
`endif
        for (int i = 0; i < 7; i++) begin
            hit_x = 5'(tbl[i].x); hit_y = 5'(tbl[i].y); hit_req = 1'b1;
            model_hit(tbl[i].x, tbl[i].y, res);
            @(posedge pclk);
            @(negedge pclk);
            hit_req = 1'b0;
            check($sformatf("vec%0d_ack", i), {31'd0, hit_ack}, 1);
            check($sformatf("vec%0d_result", i), {30'd0, hit_result}, tbl[i].res);
            check($sformatf("vec%0d_bricks", i), {23'd0, bricks_left}, tbl[i].bricks);
        end
        q_x = 5'd4; q_y = 5'd5; #1;
`ifdef MAP_BRICK_HP_EN
        check("q_tile_4_5", {30'd0, q_tile}, 1);
`else
        check("q_tile_4_5", {30'd0, q_tile}, 0);
`endif
        map_rd_x = 5'd30; map_rd_y = 5'd2; #1 check("tile_30_2", {30'd0, map_tile}, 2);
        @(negedge pclk);

        // Back-to-back hits on the same brick.
        hit_x = 5'd20; hit_y = 5'd10; hit_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            model_hit(20, 10, exp_res);
            @(posedge pclk);
            @(negedge pclk);
            check($sformatf("b2b%0d_ack", k), {31'd0, hit_ack}, 1);
            check($sformatf("b2b%0d_result", k), {30'd0, hit_result}, exp_res);
            check($sformatf("b2b%0d_bricks", k), {23'd0, bricks_left}, m_bricks);
        end
        hit_req = 1'b0;

        // Randomized hits and reads against the model.
        for (int i = 0; i < 400; i++) begin
            rx = $urandom_range(26, 0); ry = $urandom_range(19, 0);
            map_rd_x = 5'(rx); map_rd_y = 5'(ry);
            q_x = 5'($urandom_range(31, 0)); q_y = 5'($urandom_range(31, 0));
            #1;
            check("rnd_map_tile", {30'd0, map_tile}, model_rd(rx, ry));
            check("rnd_q_tile", {30'd0, q_tile}, model_rd(int'(q_x), int'(q_y)));
            req = $urandom_range(1, 0);
            if ($urandom_range(3, 0) != 0) begin
                hx = $urandom_range(21, 3); hy = $urandom_range(14, 3);
            end else begin
                hx = $urandom_range(31, 0); hy = $urandom_range(31, 0);
            end
            hit_x = 5'(hx); hit_y = 5'(hy); hit_req = req[0];
            exp_res = 0;
            if (req != 0) model_hit(hx, hy, exp_res);
            @(posedge pclk);
            @(negedge pclk);
            check("rnd_ack", {31'd0, hit_ack}, req);
            if (req != 0) check("rnd_result", {30'd0, hit_result}, exp_res);
            check("rnd_bricks", {23'd0, bricks_left}, m_bricks);
        end
        hit_req = 1'b0;

        // load coincident with hit_req, hit_req held through INIT.
        hit_x = 5'd4; hit_y = 5'd3; hit_req = 1'b1; load = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        load = 1'b0;
        check("load_ack", {31'd0, hit_ack}, 0);
        check("load_ready", {31'd0, ready}, 0);
        check("load_bricks", {23'd0, bricks_left}, 0);
        map_rd_x = 5'd12; map_rd_y = 5'd8; q_x = 5'd30; q_y = 5'd2; #1;
        check("init_map_tile", {30'd0, map_tile}, 0);
        check("init_q_tile", {30'd0, q_tile}, 0);
        wait_ready(cyc, acks);
        hit_req = 1'b0;
        check("load_ready_latency", cyc, 450);
        check("init_hit_acks", acks, 0);
        check("load_bricks_ready", {23'd0, bricks_left}, 40);
        model_reset();
        full_map_check();

        // rst asserted 100 cycles into INIT.
        load = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        load = 1'b0;
        repeat (100) @(posedge pclk);
        @(negedge pclk);
        rst = 1'b1;
        @(posedge pclk);
        @(negedge pclk);
        check_reset_outputs("mid_rst");
        rst = 1'b0;
        wait_ready(cyc, acks);
        check("rst_ready_latency", cyc, 450);
        check("rst_bricks", {23'd0, bricks_left}, 40);
        model_reset();
        full_map_check();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/map_store.md
# map_store

Tile-map owner for the tank game: holds the 25×18 grid of 2-bit tiles (0 empty, 1 brick, 2 steel, 3 reserved) that the renderer reads through its map read port. It loads a built-in layout after reset or on request, serves two zero-latency read ports (render and collision), and applies bullet hits that damage or destroy bricks. It sits between the game logic and the renderer and is the single writer of map state.

## Interface
- MAP_W, 25: tile columns, 8 px each.
- MAP_H, 18: tile rows, covering the 144-px game area.
- LAYOUT, 0: built-in layout select. 0 is the arena, 1 is an all-empty map.

- pclk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- load  in  1  single-cycle pulse that restarts layout initialization.
- ready  out  1  map initialized and accepting hits.
- map_rd_x  in  5  render-port tile column.
- map_rd_y  in  5  render-port tile row.
- map_tile  out  2  render-port tile, combinational.
- q_x  in  5  collision-port tile column.
- q_y  in  5  collision-port tile row.
- q_tile  out  2  collision-port tile, combinational.
- hit_req  in  1  bullet impact request.
- hit_x  in  5  impact tile column.
- hit_y  in  5  impact tile row.
- hit_ack  out  1  one-cycle pulse, hit processed.
- hit_result  out  2  valid with hit_ack. Codes: 0 empty, 1 brick damaged, 2 brick destroyed, 3 steel or out-of-range.
- bricks_left  out  9  count of remaining brick tiles.

## Operation
- Storage: MAP_W*MAP_H entries, addressed as y*MAP_W+x (9 bits).
- States are INIT and READY. Reset enters INIT with the scan counter at (0,0).
- INIT:
  - Writes one tile per cycle in raster order (x fastest) from the layout ROM.
  - bricks_left counts up on every brick written.
  - After tile (MAP_W-1, MAP_H-1) is written, the next state is READY.
- READY:
  - On hit_req, read tile (hit_x, hit_y).
  - Empty tile: result 0, no write.
  - Steel tile: result 3, no write.
  - Brick tile: destroyed (result 2) or damaged (result 1); see Configuration.
  - A destroyed brick writes 0 to the tile and decrements bricks_left.
- load in any state: return to INIT at (0,0), bricks_left cleared to 0, ready goes low.
- Out-of-range coordinates (x≥MAP_W or y≥MAP_H):
  - Both read ports return 2 (steel), so the area outside the map acts as a solid boundary.
  - A hit there returns result 3.
- During INIT, both read ports return 0.
- Layout 0 (bricks_left=40 after INIT):
  - Steel at x=12, y=7..10.
  - Brick at x∈{4,20}, y=3..14.
  - Brick at y∈{3,14}, x=8..16 except x=12.
  - All other tiles empty.

## Timing
- Read ports: zero latency, combinational from address and current storage. The renderer registers its rgb output on the same edge.
- hit_req is sampled on the pclk edge while ready=1.
- hit_ack and hit_result are registered and appear on the cycle after the accepting edge.
- The tile write and the bricks_left update are visible on that same following cycle.
- Back-to-back hit_req every cycle is supported. A second hit on the same tile in the next cycle sees the updated tile.
- hit_req while ready=0: dropped, no ack.
- load and hit_req in the same cycle: load wins and the hit is dropped.
- ready rises MAP_W*MAP_H cycles (450 at defaults) after the rst-deassert edge or the load edge.
- Reset values: ready=0, hit_ack=0, hit_result=0, bricks_left=0, scan counter (0,0), damage bits cleared.
- rst asserted in the middle of INIT or READY: same as reset, and the map is fully reloaded.

## Configuration
- MAP_BRICK_HP_EN defined:
  - Each brick carries a damage bit, cleared in INIT.
  - First hit on a brick sets the bit and returns 1; the tile stays 1.
  - Second hit writes 0, returns 2 and decrements bricks_left.
- MAP_BRICK_HP_EN undefined:
  - No damage storage.
  - Every brick hit returns 2 and destroys the brick immediately.

## Structure
- Shared package holds:
  - Tile codes TILE_EMPTY, TILE_BRICK, TILE_STEEL.
  - Hit result codes HIT_NONE, HIT_DAMAGED, HIT_DESTROYED, HIT_SOLID.
  - Map dimensions and TILE_PX=8, shared with the renderer.
- One sub-module, map_layout_rom: combinational (layout, x, y) → tile. Used only by INIT.

## Test plan
- Reset released with LAYOUT=0 → ready rises exactly 450 cycles later; bricks_left=40; map_tile(12,8)=2; map_tile(4,3)=1; map_tile(0,0)=0.
- hit_req at (4,5), macro off → next cycle hit_ack=1, hit_result=2, q_tile(4,5)=0, bricks_left=39.
- With MAP_BRICK_HP_EN: two consecutive-cycle hits at (20,10) → results 1 then 2; bricks_left drops 40→39 only on the second hit.
- Hits at (12,7), (0,0) and (30,2) → results 3, 0, 3 with no change to bricks_left; map_tile(30,2)=2.
- hit_req during INIT, and hit_req coincident with load → no hit_ack, map reinitialized, bricks_left=40 at ready.
- rst asserted 100 cycles into INIT, then released → all outputs at reset values; ready rises after 450 cycles with a full layout.
